// File: rtl/spi_master_pkg.sv
// spi_master_pkg: register map, STATUS/CONTROL bit positions and FSM states for spi_master_fifo
package spi_master_pkg;

  localparam logic [2:0] A_RXDATA  = 3'd0;
  localparam logic [2:0] A_TXDATA  = 3'd1;
  localparam logic [2:0] A_STATUS  = 3'd2;
  localparam logic [2:0] A_CONTROL = 3'd3;
  localparam logic [2:0] A_CLKDIV  = 3'd4;
  localparam logic [2:0] A_SSEL    = 3'd5;
  localparam logic [2:0] A_LEVEL   = 3'd6;

  localparam int S_TMT  = 1;
  localparam int S_TRDY = 2;
  localparam int S_RRDY = 3;
  localparam int S_TOE  = 4;
  localparam int S_ROE  = 5;
  localparam int S_BUSY = 6;

  localparam int C_CPOL = 8;
  localparam int C_CPHA = 9;
  localparam int C_CONT = 10;
  localparam int C_LSBF = 11;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

endpackage

// File: rtl/spi_master_sync_fifo.sv
// spi_master_sync_fifo: synchronous FIFO with extra-bit pointers; pushes when full are rejected
module spi_master_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  // pointer update; wrap is implicit in the extra-bit arithmetic
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(do_push);
      rd_ptr <= rd_ptr + (AW+1)'(do_pop);
    end
  end
  // storage write, no reset needed on data
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/spi_master_fifo.sv
// spi_master_fifo: Avalon-MM SPI master with TX/RX FIFOs, CPOL/CPHA, divider, continuous mode (LSB-first option: SPI_MASTER_LSB_FIRST_EN)
module spi_master_fifo
  import spi_master_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_SS     = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [2:0]        address,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = $clog2(2 * DATA_W);

  logic wr_q, rd_q, wr_stb, rd_stb;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [DATA_W-1:0] tx_dout, rx_dout, tx_sh, rx_sh;
  logic [LW-1:0] tx_lvl, rx_lvl;
  logic cont, cpha, cpol, lsbf, toe, roe;
  logic [6:1] ie;
  logic [DIV_W-1:0] clkdiv, div_l, div_cnt;
  logic [NUM_SS-1:0] ssel;
  logic cont_l, cpha_l, cpol_l, lsbf_l;
  logic cpha_n, lsbf_n;
  logic [EW-1:0] edge_cnt;
  logic tick, last_edge, sample, drive;
  logic start, reload, shift_edge, done;
  logic [15:0] status, control_rd, rd_mux;
  logic unused_ok;
  state_t state, state_n;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic l);
    return l ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w, input logic l);
    return l ? w >> 1 : w << 1;
  endfunction

  assign unused_ok = &{writedata, read_n};
  assign wr_stb  = chipselect & ~write_n & ~wr_q;
  assign rd_stb  = chipselect & ~read_n & ~rd_q;
  assign tx_push = wr_stb && address == A_TXDATA;
  assign rx_pop  = rd_stb && address == A_RXDATA && !rx_empty;

  spi_master_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(tx_push), .pop(tx_pop),
    .din(writedata[DATA_W-1:0]), .dout(tx_dout),
    .full(tx_full), .empty(tx_empty), .level(tx_lvl)
  );

  spi_master_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(rx_pop),
    .din(rx_sh), .dout(rx_dout),
    .full(rx_full), .empty(rx_empty), .level(rx_lvl)
  );

  // request history so a two-cycle bus access strobes only once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= chipselect & ~write_n;
      rd_q <= chipselect & ~read_n;
    end
  end

  // software-visible configuration and sticky overrun flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {cont, cpha, cpol} <= '0;
      ie     <= '0;
      clkdiv <= '0;
      ssel   <= NUM_SS'(1);
      toe    <= 1'b0;
      roe    <= 1'b0;
    end else begin
      if (wr_stb && address == A_CONTROL) begin
        {cont, cpha, cpol} <= writedata[C_CONT:C_CPOL];
        ie <= writedata[6:1];
      end
      if (wr_stb && address == A_CLKDIV) clkdiv <= writedata[DIV_W-1:0];
      if (wr_stb && address == A_SSEL) ssel <= writedata[NUM_SS-1:0];
      toe <= (toe & ~(wr_stb && address == A_STATUS)) | (tx_push & tx_full);
      roe <= (roe & ~(wr_stb && address == A_STATUS)) | (rx_push & rx_full);
    end
  end

`ifdef SPI_MASTER_LSB_FIRST_EN
  // bit-order select, only present in the LSB-first build
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lsbf <= 1'b0;
    else if (wr_stb && address == A_CONTROL) lsbf <= writedata[C_LSBF];
  end
`else
  assign lsbf = 1'b0;
`endif

  assign status = 16'({state != IDLE, roe, toe, ~rx_empty, ~tx_full, tx_empty & (state == IDLE), 1'b0});
  assign control_rd = 16'({lsbf, cont, cpha, cpol, 1'b0, ie, 1'b0});
  assign rd_mux = address == A_RXDATA  ? (rx_empty ? 16'd0 : 16'(rx_dout)) :
                  address == A_STATUS  ? status :
                  address == A_CONTROL ? control_rd :
                  address == A_CLKDIV  ? 16'(clkdiv) :
                  address == A_SSEL    ? 16'(ssel) :
                  address == A_LEVEL   ? {8'(rx_lvl), 8'(tx_lvl)} : 16'd0;

  // registered read data and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_stb ? rd_mux : readdata;
      irq      <= |(status[6:1] & ie);
    end
  end

  assign tick      = (state != IDLE) && (div_cnt == div_l);
  assign last_edge = edge_cnt == EW'(2 * DATA_W - 1);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end

  // FSM next state
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = tx_empty ? IDLE : SETUP;
      SETUP: state_n = tick ? SHIFT : SETUP;
      SHIFT: state_n = (tick && last_edge) ? HOLD : SHIFT;
      HOLD:  state_n = !tick ? HOLD : (cont_l && !tx_empty) ? SHIFT : IDLE;
    endcase
  end

  // FSM control strobes for the datapath and FIFOs
  always_comb begin
    start      = state == IDLE && !tx_empty;
    reload     = state == HOLD && tick && cont_l && !tx_empty;
    tx_pop     = start | reload;
    rx_push    = state == HOLD && tick;
    shift_edge = state == SHIFT && tick;
    done       = rx_push && !reload;
    cpha_n     = start ? cpha : cpha_l;
    lsbf_n     = start ? lsbf : lsbf_l;
    sample     = cpha_l ? edge_cnt[0] : ~edge_cnt[0];
    drive      = cpha_l ? ~edge_cnt[0] : (edge_cnt[0] & ~last_edge);
  end

  // shift datapath: divider, sclk/mosi/ss_n generation and miso capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= '1;
      {cont_l, cpha_l, cpol_l, lsbf_l} <= '0;
      div_l    <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else begin
      div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + 1'b1;
      if (state == IDLE) sclk <= cpol;
      if (start) begin
        {cont_l, cpha_l, cpol_l, lsbf_l} <= {cont, cpha, cpol, lsbf};
        div_l <= clkdiv;
        ss_n  <= ~ssel;
      end
      if (tx_pop) begin
        tx_sh    <= cpha_n ? tx_dout : advance(tx_dout, lsbf_n);
        mosi     <= cpha_n ? mosi : first_bit(tx_dout, lsbf_n);
        edge_cnt <= '0;
      end
      if (shift_edge) begin
        sclk     <= ~sclk;
        edge_cnt <= edge_cnt + 1'b1;
        if (sample) rx_sh <= lsbf_l ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
        if (drive) begin
          mosi  <= first_bit(tx_sh, lsbf_l);
          tx_sh <= advance(tx_sh, lsbf_l);
        end
      end
      if (done) ss_n <= '1;
    end
  end

endmodule
